shift_seq_unit: RTL and testbench
=================================

# shift_seq_unit

Iterative 32-bit shifter that consumes the 5-bit shift amount produced by the shift-quantity selector and applies it to an operand from the register datapath, one bit position per clock. It sits between the shift-amount mux and the write-back mux. It is driven by the multicycle control unit through a start/done handshake and holds its result until the next operation.

## Interface
Parameters:
- none (width fixed at 32 data bits, 5 shift-amount bits)

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk
- start  in  1  request a new operation; accepted only in IDLE
- op  in  3  operation: 000 SLL, 001 SRL, 010 SRA, 011 ROR, 100 ROL, 101–111 PASS
- data_in  in  32  operand, latched on the accepting edge
- shamt  in  5  shift amount 0–31 from the shift-quantity mux, latched on the accepting edge
- data_out  out  32  working/result register
- busy  out  1  high in SHIFT and DONE
- done  out  1  one-cycle pulse; data_out is valid while it is high

## Operation
- States:
  - IDLE: waiting for start.
  - SHIFT: iterating.
  - DONE: result presented.
- IDLE, start=1, edge E0:
  - Latch data_out←data_in, cnt←shamt, op_r←op.
  - Next state is SHIFT if shamt≠0, otherwise DONE.
- SHIFT, each edge: apply a 1-bit step to data_out per op_r and decrement cnt.
  - SLL: {d[30:0],0}
  - SRL: {0,d[31:1]}
  - SRA: {d[31],d[31:1]}
  - ROR: {d[0],d[31:1]}
  - ROL: {d[30:0],d[31]}
  - PASS: d unchanged; cnt still counts.
  - When cnt decrements from 1 to 0, go to DONE.
- DONE: done=1 for exactly one cycle, then unconditionally return to IDLE.
- Shift amount is always taken as 0–31 unsigned. No modulo or width extension is needed beyond the 5 bits.
- start is ignored (no latch, no error) in SHIFT and DONE. Inputs data_in, shamt and op may change freely after E0.
- data_out:
  - Shows intermediate values during SHIFT.
  - Holds the final result through DONE and IDLE until the next accepted start.
- busy = (state≠IDLE). done = (state==DONE).
- Reset (reset=0 at an edge, any state, including mid-shift):
  - state←IDLE, data_out←32'h0, cnt←0, op_r←000.
  - done=0, busy=0.
  - The aborted operation produces no done pulse.
  - Reset dominates start in the same cycle.

## Timing
- Start is sampled at edge E0. For shift amount N, done is high in the cycle following edge E_N: N+1 cycles after the start cycle.
  - N=0: done in the cycle after E0.
  - N=31: done 32 cycles after the start cycle.
- Throughput: the next start is accepted no earlier than the IDLE cycle after DONE, so one operation takes N+2 cycles from start to start.
- All outputs are registered and there are no combinational input→output paths. busy and done derive from the state register only.
- Reset values: data_out=0, busy=0, done=0. On the first cycle after reset is released, start is accepted normally.

## Test plan
- SLL: data_in=32'h0000_0001, shamt=4, op=000, start for 1 cycle -> busy=1 from the next cycle; done exactly 5 cycles after the start cycle; data_out=32'h0000_0010; busy drops one cycle later.
- SRA/SRL: data_in=32'h8000_0000, shamt=31 -> op=010 gives 32'hFFFF_FFFF, op=001 gives 32'h0000_0001; done 32 cycles after start in both cases.
- Rotate and zero amount:
  - ROR of 32'h0000_0001 by 1 -> 32'h8000_0000.
  - ROL of 32'h8000_0001 by 4 -> 32'h0000_0018.
  - shamt=0 with data_in=32'hDEAD_BEEF, op=000 -> done in the next cycle, data_out=32'hDEAD_BEEF.
- Start while busy: start SLL of 32'h1 by 8, then pulse start with data_in=32'hFFFF_FFFF, shamt=1 in cycle 3 -> second request ignored; single done at cycle 9; data_out=32'h0000_0100.
- Reset mid-shift: start SRL of 32'hF000_0000 by 20, drive reset=0 at cycle 6 -> next cycle data_out=0, busy=0, no done pulse ever. A new SLL of 32'h3 by 2 issued after reset release completes with 32'hC in 3 cycles.
- PASS op=111, shamt=3, data_in=32'h1234_5678 -> data_out stays 32'h1234_5678 and done arrives 4 cycles after start.

Source files
------------

// File: rtl/shift_seq_unit_if.sv
// shift_seq_unit_if: start/done handshake and data bus of the iterative shifter
interface shift_seq_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic [31:0] data_out;
  logic        busy;
  logic        done;
  modport master (output start, op, data_in, shamt, input data_out, busy, done);
  modport slave (input start, op, data_in, shamt, output data_out, busy, done);
endinterface

// File: rtl/shift_seq_unit.sv
// shift_seq_unit: iterative 32-bit shifter/rotator, one bit position per clock
module shift_seq_unit (
  input logic             clk,
  input logic             reset,
  shift_seq_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t      state, state_nx;
  logic [31:0] d, d_nx, step;
  logic [4:0]  cnt, cnt_nx;
  logic [2:0]  op_r, op_nx;
  // single-bit step of the latched operation; codes 5-7 leave the value alone
  always_comb begin
    step = op_r == 3'd0 ? {d[30:0], 1'b0} :
           op_r == 3'd1 ? {1'b0, d[31:1]} :
           op_r == 3'd2 ? {d[31], d[31:1]} :
           op_r == 3'd3 ? {d[0], d[31:1]} :
           op_r == 3'd4 ? {d[30:0], d[31]} : d;
  end
  // next-state and datapath updates: accept in IDLE, iterate in SHIFT, leave DONE unconditionally
  always_comb begin
    state_nx = state;
    d_nx     = d;
    cnt_nx   = cnt;
    op_nx    = op_r;
    if (state == IDLE && bus.start) begin
      d_nx     = bus.data_in;
      cnt_nx   = bus.shamt;
      op_nx    = bus.op;
      state_nx = bus.shamt == 5'd0 ? DONE : SHIFT;
    end else if (state == SHIFT) begin
      d_nx     = step;
      cnt_nx   = cnt - 5'd1;
      state_nx = cnt == 5'd1 ? DONE : SHIFT;
    end else if (state == DONE) begin
      state_nx = IDLE;
    end
  end
  // registers; active-low synchronous reset aborts any operation without a done pulse
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      d     <= 32'h0;
      cnt   <= 5'd0;
      op_r  <= 3'd0;
    end else begin
      state <= state_nx;
      d     <= d_nx;
      cnt   <= cnt_nx;
      op_r  <= op_nx;
    end
  end
  assign bus.data_out = d;
  assign bus.busy     = state != IDLE;
  assign bus.done     = state == DONE;
endmodule

// File: tb/tb_shift_seq_unit.sv
// tb_shift_seq_unit: table-driven, hand-written and randomized checks of the iterative shifter
module tb_shift_seq_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  shift_seq_unit_if bus ();
  shift_seq_unit dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    string       nm;
    logic [31:0] d;
    logic [4:0]  s;
    logic [2:0]  o;
    logic [31:0] exp_d;
  } vec_t;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask
  function automatic logic [31:0] ref_model(input logic [31:0] d, input int n, input logic [2:0] o);
    logic [63:0] dd;
    logic signed [31:0] sd;
    dd = {d, d};
    sd = d;
    case (o)
      3'd0: return d << n;
      3'd1: return d >> n;
      3'd2: return 32'(sd >>> n);
      3'd3: begin dd = dd >> n; return dd[31:0]; end
      3'd4: begin dd = dd << n; return dd[63:32]; end
      default: return d;
    endcase
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input string nm, input logic [31:0] d, input logic [4:0] s,
                        input logic [2:0] o, input logic [31:0] exp_d);
    int lat;
    bus.start = 1'b1;
    bus.data_in = d;
    bus.shamt = s;
    bus.op = o;
    tick();
    bus.start = 1'b0;
    bus.data_in = $urandom;
    bus.shamt = 5'($urandom);
    bus.op = 3'($urandom);
    lat = 1;
    while (!bus.done && lat < 40) begin
      check({nm, " busy"}, 32'(bus.busy), 32'd1);
      if (o >= 3'd5) check({nm, " pass hold"}, bus.data_out, d);
      tick();
      lat++;
    end
    check({nm, " latency"}, 32'(lat), 32'(s) + 32'd1);
    check({nm, " result"}, bus.data_out, exp_d);
    check({nm, " busy at done"}, 32'(bus.busy), 32'd1);
    tick();
    check({nm, " done drops"}, 32'(bus.done), 32'd0);
    check({nm, " busy drops"}, 32'(bus.busy), 32'd0);
    check({nm, " result held"}, bus.data_out, exp_d);
  endtask
  initial begin
    vec_t vt[8];
    int ndone, first;
    logic [31:0] dval, rd;
    logic [4:0] rs;
    logic [2:0] ro;
    vt[0] = '{"sll", 32'h0000_0001, 5'd4, 3'd0, 32'h0000_0010};
    vt[1] = '{"sra31", 32'h8000_0000, 5'd31, 3'd2, 32'hFFFF_FFFF};
    vt[2] = '{"srl31", 32'h8000_0000, 5'd31, 3'd1, 32'h0000_0001};
    vt[3] = '{"ror1", 32'h0000_0001, 5'd1, 3'd3, 32'h8000_0000};
    vt[4] = '{"rol4", 32'h8000_0001, 5'd4, 3'd4, 32'h0000_0018};
    vt[5] = '{"zero", 32'hDEAD_BEEF, 5'd0, 3'd0, 32'hDEAD_BEEF};
    vt[6] = '{"pass", 32'h1234_5678, 5'd3, 3'd7, 32'h1234_5678};
    vt[7] = '{"pass5", 32'hA5A5_0F0F, 5'd2, 3'd5, 32'hA5A5_0F0F};
    bus.start = 1'b1;
    bus.data_in = 32'hFFFF_FFFF;
    bus.shamt = 5'd3;
    bus.op = 3'd0;
    repeat (3) tick();
    check("reset data_out", bus.data_out, 32'h0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    bus.start = 1'b0;
    reset = 1'b1;
    foreach (vt[i]) run_op(vt[i].nm, vt[i].d, vt[i].s, vt[i].o, vt[i].exp_d);
    bus.start = 1'b1;
    bus.data_in = 32'h0000_0001;
    bus.shamt = 5'd8;
    bus.op = 3'd0;
    tick();
    ndone = 0;
    first = 0;
    dval = 32'h0;
    for (int i = 1; i <= 16; i++) begin
      if (bus.done) begin
        ndone++;
        if (first == 0) begin
          first = i;
          dval = bus.data_out;
        end
      end
      bus.start = (i == 3);
      bus.data_in = 32'hFFFF_FFFF;
      bus.shamt = 5'd1;
      tick();
    end
    bus.start = 1'b0;
    check("busy-start done count", 32'(ndone), 32'd1);
    check("busy-start done cycle", 32'(first), 32'd9);
    check("busy-start result", dval, 32'h0000_0100);
    bus.start = 1'b1;
    bus.data_in = 32'hF000_0000;
    bus.shamt = 5'd20;
    bus.op = 3'd1;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i < 6; i++) tick();
    check("mid-shift value", bus.data_out, 32'hF000_0000 >> 5);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("abort data_out", bus.data_out, 32'h0);
    check("abort busy", 32'(bus.busy), 32'd0);
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.done) ndone++;
      tick();
    end
    check("abort no done", 32'(ndone), 32'd0);
    run_op("after reset sll", 32'h0000_0003, 5'd2, 3'd0, 32'h0000_000C);
    for (int i = 0; i < 40; i++) begin
      rd = $urandom;
      rs = 5'($urandom);
      ro = 3'($urandom_range(0, 7));
      run_op($sformatf("rand%0d op%0d n%0d", i, ro, rs), rd, rs, ro, ref_model(rd, int'(rs), ro));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
